// File: rtl/param_sync_ram.sv
// param_sync_ram: single-port synchronous RAM with a self-clearing sequence after reset
module param_sync_ram #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] datain,
  input  logic [ADDR_W-1:0] addr,
  input  logic              read,
  input  logic              write,
  output logic [DATA_W-1:0] dataout,
  output logic              valid,
  output logic              busy,
  output logic              err
);
  typedef enum logic {CLEAR, RUN} state_t;
  localparam logic [ADDR_W-1:0] LAST = '1;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, waddr;
  logic [DATA_W-1:0] dout_q, dout_d, wdata;
  logic valid_q, valid_d, err_q, err_d, clr, rd, wr, we;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_comb begin
    clr = state_q == CLEAR;
    rd = !clr && read && !write;
    wr = !clr && write && !read;
    state_d = rst ? CLEAR : (clr && cnt_q == LAST) ? RUN : state_q;
    cnt_d = (rst || !clr) ? '0 : cnt_q + 1'b1;
    we = !rst && (clr || wr);
    waddr = clr ? cnt_q : addr;
    wdata = clr ? INIT_VAL : datain;
    dout_d = rst ? '0 : rd ? mem[addr] : dout_q;
    valid_d = !rst && rd;
    err_d = !rst && !clr && read && write;
  end
  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q <= cnt_d;
    dout_q <= dout_d;
    valid_q <= valid_d;
    err_q <= err_d;
  end
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign dataout = dout_q;
  assign valid = valid_q;
  assign err = err_q;
  assign busy = state_q == CLEAR;
endmodule

// File: tb/tb_param_sync_ram.sv
// tb_param_sync_ram: random and directed checks against a word-array reference model
module tb_param_sync_ram;
  logic clk = 0, rst = 1, read = 0, write = 0;
  logic [3:0] datain = 0, addr = 0, dataout;
  logic valid, busy, err;
  int n_chk = 0, n_fail = 0, left = 16, n;
  logic [3:0] m [16];
  logic [3:0] ed = 0;
  logic ev = 0, ee = 0;

  param_sync_ram #(.DATA_W(4), .ADDR_W(4), .INIT_VAL(4'h0)) dut (
    .clk(clk), .rst(rst), .datain(datain), .addr(addr), .read(read),
    .write(write), .dataout(dataout), .valid(valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic rd, input logic wr, input logic [3:0] a, input logic [3:0] d);
    rst = r; read = rd; write = wr; addr = a; datain = d;
    @(posedge clk);
    if (r) begin
      left = 16; ed = 0; ev = 0; ee = 0;
      for (int i = 0; i < 16; i++) m[i] = 4'h0;
    end else if (left > 0) begin
      left--; ev = 0; ee = 0;
    end else begin
      ev = rd && !wr;
      ee = rd && wr;
      if (ev) ed = m[a];
      if (wr && !rd) m[a] = d;
    end
    @(negedge clk);
    check("busy", busy, left > 0);
    check("valid", valid, ev);
    check("err", err, ee);
    check("dataout", dataout, ed);
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    do begin
      cyc(0, 0, 0, 0, 0);
      cnt++;
    end while (busy && cnt < 40);
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 4'h3, 4'h7);
    wait_idle(n);
    check("busy_len", n, 16);
    cyc(0, 1, 0, 4'hA, 0);
    check("clear_read", {valid, dataout}, 5'h10);
    cyc(0, 0, 1, 4'h2, 4'h4);
    cyc(0, 1, 0, 4'h2, 0);
    check("raw_read", {valid, dataout}, 5'h14);
    cyc(0, 0, 0, 0, 0);
    check("hold", {valid, dataout}, 5'h04);
    cyc(0, 0, 1, 4'h3, 4'h6);
    cyc(0, 1, 1, 4'h3, 4'hF);
    check("conflict", {err, valid}, 2'b10);
    cyc(0, 1, 0, 4'h3, 0);
    check("after_conflict", dataout, 4'h6);
    cyc(0, 0, 1, 4'hF, 4'hA);
    cyc(0, 0, 1, 4'h0, 4'h1);
    cyc(0, 1, 0, 4'hF, 0);
    check("wrap_hi", dataout, 4'hA);
    cyc(0, 1, 0, 4'h0, 0);
    check("wrap_lo", dataout, 4'h1);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 4'h6, 4'hB);
    cyc(1, 0, 1, 4'h6, 4'hB);
    cyc(0, 0, 1, 4'h6, 4'hB);
    wait_idle(n);
    check("restart_len", n + 1, 16);
    cyc(0, 1, 0, 4'h6, 0);
    check("busy_write_ignored", {valid, dataout}, 5'h10);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, i[3:0], 4'hF);
    cyc(1, 0, 0, 0, 0);
    wait_idle(n);
    check("rerun_len", n, 16);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 0, i[3:0], 0);
      check("cleared", {valid, dataout}, 5'h10);
    end
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 199) == 0, 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/param_sync_ram.md
PARAM_SYNC_RAM -- requirements
Module: param_sync_ram

Interface
REQ-001 The block SHALL have parameter DATA_W, default 4, meaning data word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning address width, with depth fixed at 2**ADDR_W words.
REQ-003 The block SHALL have parameter INIT_VAL, default 0, meaning the DATA_W-bit value written to every word by the clear sequence.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, named as below.
REQ-005 Port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1 bit: synchronous active-high reset.
REQ-007 Port datain, input, DATA_W bits: write data.
REQ-008 Port addr, input, ADDR_W bits: read/write word address.
REQ-009 Port read, input, 1 bit: read request for the current cycle.
REQ-010 Port write, input, 1 bit: write request for the current cycle.
REQ-011 Port dataout, output, DATA_W bits: registered read data.
REQ-012 Port valid, output, 1 bit: one-cycle pulse marking new data on dataout.
REQ-013 Port busy, output, 1 bit: high while the clear sequence runs and requests are ignored.
REQ-014 Port err, output, 1 bit: one-cycle pulse flagging a rejected simultaneous read and write.

Function
REQ-015 The block SHALL implement a two-state FSM, CLEAR and RUN, plus an ADDR_W-bit clear counter.
REQ-016 In CLEAR, each cycle SHALL write INIT_VAL to mem[counter] and increment the counter.
REQ-017 CLEAR SHALL transition to RUN on the cycle after the write to address 2**ADDR_W-1, with no counter wrap to 0 inside CLEAR.
REQ-018 busy SHALL be 1 in CLEAR and 0 in RUN, so it stays high for exactly 2**ADDR_W cycles after rst deasserts.
REQ-019 In CLEAR, read and write SHALL be ignored: no memory update except the clear write, and no valid or err pulse.
REQ-020 In RUN, write=1 and read=0 SHALL store datain to mem[addr] at the clock edge.
REQ-021 In RUN, read=1 and write=0 SHALL load mem[addr] into dataout at the clock edge and assert valid=1 for that following cycle (latency 1).
REQ-022 In RUN, read=1 and write=1 SHALL perform neither operation, leave memory and dataout unchanged, and assert err=1 for one cycle.
REQ-023 valid and err SHALL be 0 in every cycle not covered by REQ-021 or REQ-022.
REQ-024 dataout SHALL hold its last loaded value until the next accepted read.
REQ-025 A read at an address written in the immediately preceding cycle SHALL return the newly written value.
REQ-026 Addresses SHALL be decoded modulo 2**ADDR_W over the full range 0 to 2**ADDR_W-1 with no aliasing.

Reset
REQ-027 rst=1 at a clock edge SHALL set state to CLEAR, counter to 0, dataout to 0, valid to 0, err to 0, and busy to 1 in the following cycle.
REQ-028 rst asserted mid-CLEAR SHALL restart the clear from address 0.
REQ-029 rst asserted in RUN SHALL discard the memory contents by re-running the full clear sequence.
REQ-030 While rst=1, the block SHALL hold the reset state and perform no memory writes other than holding the counter at 0.

Verification (DATA_W=4, ADDR_W=4, INIT_VAL=0)
REQ-031 Release rst, count cycles -> busy=1 for exactly 16 cycles, then 0; a read of addr 4'hA then gives dataout=4'h0, valid=1.
REQ-032 Write 4'h4 to addr 4'h2, read addr 4'h2 on the next cycle -> dataout=4'h4, valid=1 one cycle after the read, then valid=0 with dataout held at 4'h4.
REQ-033 Write 4'h6 to addr 4'h3, then assert read=1 and write=1 with datain=4'hF at addr 4'h3 -> err=1 for one cycle, valid=0; a later read of 4'h3 returns 4'h6.
REQ-034 Write 4'hA to addr 4'hF and 4'h1 to addr 4'h0, then read both -> 4'hA and 4'h1 respectively, with no aliasing at the wrap boundary.
REQ-035 Assert write of 4'hB to addr 4'h6 during busy, and pulse rst at clear count 5 -> busy runs 16 more cycles from the reset release, and a read of addr 4'h6 returns 4'h0.
REQ-036 Write 4'hF to all 16 addresses, assert rst for 1 cycle, wait for busy=0, read all addresses -> every read returns 4'h0 with valid=1.
